nios2_oci_dct_packer: RTL and testbench
=======================================

Name: nios2_oci_dct_packer

Overview:
- Producer end of the OCI direct-conditional-trace (DCT) capture path.
- Accepts one 2-bit branch-outcome record per cycle from the trace front end.
- Packs records into a 30-bit buffer with a 4-bit record count, and hands completed buffers to the trace consumer / OCI test bench over a valid/ready handshake.
- Generates the test_ending / test_has_ended status pair that the consumer samples.

Parameters:
- REC_W, 2, bits per trace record.
- DEPTH, 15, records per buffer; must satisfy DEPTH < 2**CNT_W.
- BUF_W, 30, buffer width; fixed at REC_W*DEPTH.
- CNT_W, 4, width of the record count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rec_valid  in  1  record present on rec_data.
- rec_data  in  REC_W  branch record; bit1 = taken, bit0 = record-valid tag.
- rec_ready  out  1  packer accepts record this cycle.
- flush  in  1  single-cycle request to emit a partial buffer.
- stop  in  1  single-cycle end-of-test request.
- dct_buffer  out  BUF_W  packed records; oldest in the highest occupied slot, newest in bits [1:0], unused upper bits zero.
- dct_count  out  CNT_W  number of valid records in dct_buffer (1..DEPTH).
- dct_valid  out  1  output stage holds a packet.
- dct_ready  in  1  consumer takes the packet.
- test_ending  out  1  stop accepted; final drain in progress.
- test_has_ended  out  1  final packet delivered; sticky.

Behaviour:
- Reset: all outputs are 0, except that rec_ready is 0 until the first cycle after reset deasserts. Internal acc_buf, acc_cnt, flush_pend and stop_pend are cleared.
- Reset mid-operation discards all pending records and packets without emitting them.
- Accept: when rec_valid and rec_ready, acc_buf <= {acc_buf[BUF_W-REC_W-1:0], rec_data} and acc_cnt increments.
- Stage free: out_free = !dct_valid || dct_ready.
- Transfer (xfer): occurs when out_free and one of:
  - acc_cnt == DEPTH;
  - flush_pend and acc_cnt != 0;
  - stop_pend and acc_cnt != 0.
- On xfer:
  - dct_buffer <= acc_buf and dct_count <= acc_cnt, both registered.
  - dct_valid <= 1.
  - The accumulator clears.
- Same-cycle accept on xfer: a record accepted in the xfer cycle lands in the emptied accumulator, giving acc_cnt = 1. No record is lost or duplicated.
- rec_ready = !test_ending && !test_has_ended && (acc_cnt != DEPTH || xfer).
- Latency: the packet becomes visible the cycle after the DEPTH-th record is accepted, provided the stage is free.
- dct_valid deasserts on dct_ready unless a new xfer happens in the same cycle.
- While dct_valid && !dct_ready, dct_buffer and dct_count are held stable.
- flush:
  - Sets flush_pend; cleared on xfer.
  - Cleared if acc_cnt == 0, so no empty packet is ever emitted.
  - A record accepted in the same cycle as flush is included in the flushed packet.
  - flush while the accumulator is full behaves like a normal full transfer.
- stop:
  - Sets stop_pend and test_ending, and blocks new records from the next cycle.
  - Records accepted in the stop cycle are kept.
  - Once the accumulator is empty and the last packet has handshaken (dct_valid && dct_ready, or no packet pending), test_ending drops and test_has_ended rises. test_has_ended stays high until reset.
  - stop with nothing pending: test_has_ended asserts exactly 1 cycle later.
  - stop after test_has_ended is ignored.
  - Simultaneous flush and stop: treated as stop.
- The count never wraps: acc_cnt saturates at DEPTH by backpressure.

Decomposition:
- Shared package nios2_oci_dct_pkg holds:
  - REC_W, DEPTH, BUF_W, CNT_W;
  - the record bit positions (TAKEN_BIT = 1, TAG_BIT = 0).
- One natural sub-module, nios2_oci_dct_outreg: the valid/ready holding register for {dct_buffer, dct_count}.
- Accumulator and stop/flush control stay in the top module.

Test Plan:
- Fill: 15 back-to-back records 2'b11, dct_ready = 1 -> one cycle after the 15th accept, dct_valid = 1, dct_count = 15, dct_buffer = 30'h3FFFFFFF; rec_ready stays 1 throughout.
- Partial flush: records 10, 01, 11, then flush -> dct_count = 3, dct_buffer = 30'h00000027.
- Empty flush: flush with acc_cnt = 0 -> dct_valid never asserts; flush_pend cleared.
- Backpressure: dct_ready = 0, push 31 records -> the first packet is held stable, a second 15-record accumulator fills, and rec_ready = 0 after the 30th accept. Raise dct_ready -> two packets in order (count 15, count 15), then the 31st record is accepted.
- Same-cycle accept on xfer: accept the 16th record in the xfer cycle -> packet count = 15; next flush yields count = 1 containing that record.
- Stop with a pending partial buffer (5 records) and dct_ready low for 3 cycles:
  - test_ending = 1 from the cycle after stop;
  - packet count = 5;
  - test_has_ended rises the cycle after the handshake and stays 1;
  - rec_ready stays 0.
  - Then assert reset mid-drain on a rerun -> all outputs 0 next cycle.

Source files
------------

// File: rtl/nios2_oci_dct_packer_pkg.sv
// Shared widths, depth and record layout for the DCT packer slice.
package nios2_oci_dct_pkg;

    localparam int unsigned REC_W = 2;
    localparam int unsigned DEPTH = 15;
    localparam int unsigned BUF_W = REC_W * DEPTH;
    localparam int unsigned CNT_W = 4;

    // Record layout: bit1 = branch taken, bit0 = record-valid tag.
    localparam int unsigned TAKEN_BIT = 1;
    localparam int unsigned TAG_BIT   = 0;

    typedef logic [REC_W-1:0] rec_t;
    typedef logic [BUF_W-1:0] buf_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    function automatic logic rec_taken(rec_t r);
        return r[TAKEN_BIT];
    endfunction

    function automatic logic rec_tagged(rec_t r);
        return r[TAG_BIT];
    endfunction

endpackage

// File: rtl/nios2_oci_dct_packer_if.sv
// Record input, packet output and end-of-test status of the DCT packer.
interface nios2_oci_dct_packer_if;
    import nios2_oci_dct_pkg::*;

    logic rec_valid;
    rec_t rec_data;
    logic rec_ready;
    logic flush;
    logic stop;
    buf_t dct_buffer;
    cnt_t dct_count;
    logic dct_valid;
    logic dct_ready;
    logic test_ending;
    logic test_has_ended;

    // Packer side.
    modport master (
        input  rec_valid,
        input  rec_data,
        output rec_ready,
        input  flush,
        input  stop,
        output dct_buffer,
        output dct_count,
        output dct_valid,
        input  dct_ready,
        output test_ending,
        output test_has_ended
    );

    // Trace front end / consumer side.
    modport slave (
        output rec_valid,
        output rec_data,
        input  rec_ready,
        output flush,
        output stop,
        input  dct_buffer,
        input  dct_count,
        input  dct_valid,
        output dct_ready,
        input  test_ending,
        input  test_has_ended
    );

endinterface

// File: rtl/nios2_oci_dct_outreg.sv
// Valid/ready holding register for the packed buffer and its record count.
module nios2_oci_dct_outreg
    import nios2_oci_dct_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  buf_t load_data_i,
    input  cnt_t load_cnt_i,
    input  logic out_ready_i,
    output logic out_free_o,
    output logic out_valid_o,
    output buf_t out_data_o,
    output cnt_t out_cnt_o
);

    logic valid_q;
    buf_t data_q;
    cnt_t cnt_q;

    // Load a new packet when told to; otherwise hold until the consumer takes it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
            cnt_q   <= load_cnt_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_free_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_cnt_o   = cnt_q;

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// DCT trace packer: accumulates 2-bit branch records into buffers and hands
// them to the consumer, with flush and end-of-test drain control.
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
(
    input logic                     clk,
    input logic                     reset,
    nios2_oci_dct_packer_if.master  bus
);

    buf_t acc_buf_q, acc_buf_d;
    cnt_t acc_cnt_q, acc_cnt_d;
    logic flush_pend_q, flush_pend_d;
    logic stop_pend_q, stop_pend_d;
    logic ended_q, ended_d;
    logic run_q;

    logic out_free;
    logic acc_full;
    logic acc_nonempty;
    logic xfer;
    logic rec_ready;
    logic accept;
    logic stop_take;
    logic flush_take;
    logic draining;
    logic drain_done;

    // Transfer decision, record acceptance and next-state of accumulator and control.
    always_comb begin
        acc_full     = (acc_cnt_q == DEPTH_CNT);
        acc_nonempty = (acc_cnt_q != '0);
        xfer         = out_free &&
                       (acc_full || ((flush_pend_q || stop_pend_q) && acc_nonempty));
        // run_q keeps rec_ready low until the first cycle out of reset.
        rec_ready    = run_q && !stop_pend_q && !ended_q && (!acc_full || xfer);
        accept       = bus.rec_valid && rec_ready;

        // A record taken in the xfer cycle lands in the freshly emptied accumulator.
        acc_buf_d = xfer ? '0 : acc_buf_q;
        acc_cnt_d = xfer ? '0 : acc_cnt_q;
        if (accept) begin
            acc_buf_d = {acc_buf_d[BUF_W-REC_W-1:0], bus.rec_data};
            acc_cnt_d = acc_cnt_d + cnt_t'(1);
        end

        stop_take  = bus.stop && !stop_pend_q && !ended_q;
        flush_take = bus.flush && !bus.stop;
        draining   = stop_take || stop_pend_q;
        // Finished once nothing is left to pack and the output stage is, or is
        // becoming, empty.
        drain_done = draining && (acc_cnt_d == '0) && !xfer &&
                     (!bus.dct_valid || bus.dct_ready);

        stop_pend_d  = draining && !drain_done;
        ended_d      = ended_q || drain_done;
        // Never keep a flush request against an empty accumulator.
        flush_pend_d = ((flush_pend_q && !xfer) || flush_take) && (acc_cnt_d != '0);
    end

    // Accumulator and control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_buf_q    <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            ended_q      <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            acc_buf_q    <= acc_buf_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            stop_pend_q  <= stop_pend_d;
            ended_q      <= ended_d;
            run_q        <= 1'b1;
        end
    end

    nios2_oci_dct_outreg u_outreg (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (xfer),
        .load_data_i (acc_buf_q),
        .load_cnt_i  (acc_cnt_q),
        .out_ready_i (bus.dct_ready),
        .out_free_o  (out_free),
        .out_valid_o (bus.dct_valid),
        .out_data_o  (bus.dct_buffer),
        .out_cnt_o   (bus.dct_count)
    );

    assign bus.rec_ready      = rec_ready;
    assign bus.test_ending    = stop_pend_q;
    assign bus.test_has_ended = ended_q;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed bench for the DCT packer: fill, flush, backpressure, stop and reset.
module tb_nios2_oci_dct_packer;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    nios2_oci_dct_packer_if bus ();

    nios2_oci_dct_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] d);
        bus.rec_valid = 1'b1;
        bus.rec_data  = d;
        tick();
        bus.rec_valid = 1'b0;
    endtask

    task automatic chk_pkt(input string tag, input logic [31:0] cnt, input logic [31:0] data);
        chk({tag, "_valid"}, 32'(bus.dct_valid), 32'd1);
        chk({tag, "_count"}, 32'(bus.dct_count), cnt);
        chk({tag, "_buffer"}, 32'(bus.dct_buffer), data);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.dct_valid), 32'd0);
        chk({tag, "_count"}, 32'(bus.dct_count), 32'd0);
        chk({tag, "_buffer"}, 32'(bus.dct_buffer), 32'd0);
        chk({tag, "_ending"}, 32'(bus.test_ending), 32'd0);
        chk({tag, "_ended"}, 32'(bus.test_has_ended), 32'd0);
        chk({tag, "_rec_ready"}, 32'(bus.rec_ready), 32'd0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        bus.rec_valid = 1'b0;
        bus.rec_data  = 2'b00;
        bus.flush     = 1'b0;
        bus.stop      = 1'b0;
        bus.dct_ready = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");

        reset = 1'b0;
        tick();
        chk("ready_after_reset", 32'(bus.rec_ready), 32'd1);

        // Fill: 15 records of 2'b11 with consumer ready.
        bus.dct_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus.rec_valid = 1'b1;
            bus.rec_data  = 2'b11;
            #1;
            chk("fill_rec_ready", 32'(bus.rec_ready), 32'd1);
            tick();
        end
        bus.rec_valid = 1'b0;
        chk("fill_not_yet", 32'(bus.dct_valid), 32'd0);
        tick();
        chk_pkt("fill", 32'd15, 32'h3FFF_FFFF);
        tick();
        chk("fill_drained", 32'(bus.dct_valid), 32'd0);

        // Partial flush: 10, 01, 11.
        push(2'b10);
        push(2'b01);
        push(2'b11);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        chk_pkt("partial", 32'd3, 32'h0000_0027);
        tick();
        chk("partial_drained", 32'(bus.dct_valid), 32'd0);

        // Empty flush must not emit and must not leave a stale request behind.
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("empty_flush_pend", 32'(dut.flush_pend_q), 32'd0);
        chk("empty_flush_valid", 32'(bus.dct_valid), 32'd0);
        push(2'b01);
        tick();
        tick();
        chk("no_stale_flush", 32'(bus.dct_valid), 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        chk_pkt("single", 32'd1, 32'h0000_0001);
        tick();

        // Backpressure: 15 x 10 then 15 x 01 with consumer stalled.
        bus.dct_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.rec_valid = 1'b1;
            bus.rec_data  = (i < 15) ? 2'b10 : 2'b01;
            #1;
            chk("bp_rec_ready", 32'(bus.rec_ready), 32'd1);
            tick();
        end
        bus.rec_valid = 1'b1;
        bus.rec_data  = 2'b11;
        #1;
        chk("bp_stall_ready", 32'(bus.rec_ready), 32'd0);
        chk_pkt("bp_pkt1", 32'd15, 32'h2AAA_AAAA);
        tick();
        chk("bp_still_stalled", 32'(bus.rec_ready), 32'd0);
        chk_pkt("bp_pkt1_held", 32'd15, 32'h2AAA_AAAA);
        bus.dct_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(bus.rec_ready), 32'd1);
        tick();
        bus.rec_valid = 1'b0;
        bus.dct_ready = 1'b0;
        chk_pkt("bp_pkt2", 32'd15, 32'h1555_5555);
        bus.dct_ready = 1'b1;
        tick();
        chk("bp_pkt2_taken", 32'(bus.dct_valid), 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        chk_pkt("bp_rec31", 32'd1, 32'h0000_0003);
        tick();

        // Same-cycle accept on transfer: 16th record goes into the next buffer.
        for (int i = 0; i < 16; i++) begin
            bus.rec_valid = 1'b1;
            bus.rec_data  = (i < 15) ? 2'b11 : 2'b10;
            tick();
        end
        bus.rec_valid = 1'b0;
        chk_pkt("same_cycle", 32'd15, 32'h3FFF_FFFF);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        chk_pkt("same_cycle_rec16", 32'd1, 32'h0000_0002);
        tick();

        // Stop with 5 pending records, the 5th accepted in the stop cycle.
        bus.dct_ready = 1'b0;
        push(2'b11);
        push(2'b10);
        push(2'b01);
        push(2'b00);
        bus.rec_valid = 1'b1;
        bus.rec_data  = 2'b11;
        bus.stop      = 1'b1;
        tick();
        bus.stop     = 1'b0;
        bus.rec_data = 2'b10;
        #1;
        chk("stop_ending", 32'(bus.test_ending), 32'd1);
        chk("stop_not_ended", 32'(bus.test_has_ended), 32'd0);
        chk("stop_rec_ready", 32'(bus.rec_ready), 32'd0);
        tick();
        chk_pkt("stop_pkt", 32'd5, 32'h0000_0393);
        chk("stop_ending_drain", 32'(bus.test_ending), 32'd1);
        tick();
        tick();
        chk_pkt("stop_pkt_held", 32'd5, 32'h0000_0393);
        chk("stop_not_ended_held", 32'(bus.test_has_ended), 32'd0);
        bus.dct_ready = 1'b1;
        tick();
        chk("stop_ended", 32'(bus.test_has_ended), 32'd1);
        chk("stop_ending_drop", 32'(bus.test_ending), 32'd0);
        chk("stop_drained", 32'(bus.dct_valid), 32'd0);
        tick();
        chk("stop_ended_sticky", 32'(bus.test_has_ended), 32'd1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_again_ended", 32'(bus.test_has_ended), 32'd1);
        chk("stop_again_ending", 32'(bus.test_ending), 32'd0);
        chk("stop_again_rec_ready", 32'(bus.rec_ready), 32'd0);
        bus.rec_valid = 1'b0;

        // Stop with nothing pending ends one cycle later.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("idle_stop_ended", 32'(bus.test_has_ended), 32'd1);
        chk("idle_stop_ending", 32'(bus.test_ending), 32'd0);

        // Reset in the middle of a drain discards everything.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.dct_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(2'b01);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
        chk_pkt("rerun_pkt", 32'd5, 32'h0000_0155);
        reset = 1'b1;
        tick();
        chk_all_zero("mid_drain_reset");
        reset         = 1'b0;
        bus.dct_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("post_reset_no_pkt", 32'(bus.dct_valid), 32'd0);
        chk("post_reset_rec_ready", 32'(bus.rec_ready), 32'd1);
        chk("post_reset_not_ended", 32'(bus.test_has_ended), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
